// File: rtl/rr_arb3x16.sv
// Round-robin 3:1 word arbiter with burst lock. One word is registered per accept, and dout_vld follows an accept by 1 cycle.
// A held word that is not consumed (dout_vld & !dout_rdy) stalls the stage, and rdy stays low until the word drains.
module rr_arb3x16 #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] c,
    input  logic [2:0]   vld,
    input  logic [2:0]   lock,
    output logic [2:0]   rdy,
    output logic [1:0]   s,
    output logic [W-1:0] dataout,
    output logic         dout_vld,
    input  logic         dout_rdy,
    output logic [1:0]   owner
);

    typedef enum logic {
        ST_ARB    = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t         state_q, state_d;
    logic [1:0]     owner_q, owner_d;
    logic [W-1:0]   dataout_q, dataout_d;
    logic           dout_vld_q, dout_vld_d;

    logic           can_acc;
    logic           cand;
    logic           acc;
    logic [1:0]     pick;
    logic [1:0]     idx;
    logic [1:0]     sel;
    logic [W-1:0]   mux_dat;

    // Candidate search. In ARB the search walks owner+1, owner+2, owner (wrapping 2->0).
    // In LOCKED the only candidate is the current owner.
    always_comb begin
        can_acc = !dout_vld_q || dout_rdy;
        cand    = 1'b0;
        pick    = owner_q;
        idx     = owner_q;
        if (state_q == ST_LOCKED) begin
            cand = vld[owner_q];
        end else begin
            for (int k = 0; k < 3; k++) begin
                idx = (idx == 2'd2) ? 2'd0 : idx + 2'd1;
                if (!cand && vld[idx]) begin
                    cand = 1'b1;
                    pick = idx;
                end
            end
        end
    end

    always_comb begin
        sel = reset ? 2'd0 : (cand ? pick : owner_q);
        acc = cand && can_acc && !reset;
        rdy = acc ? (3'b001 << pick) : 3'b000;
        case (sel)
            2'd1:    mux_dat = b;
            2'd2:    mux_dat = c;
            default: mux_dat = a;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        dataout_d  = dataout_q;
        dout_vld_d = dout_vld_q;
        if (acc) begin
            dataout_d  = mux_dat;
            dout_vld_d = 1'b1;
            owner_d    = pick;
            state_d    = lock[pick] ? ST_LOCKED : ST_ARB;
        end else if (dout_vld_q && dout_rdy) begin
            dout_vld_d = 1'b0;
        end
    end

    // owner resets to C so that A wins the first arbitration.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_ARB;
            owner_q    <= 2'd2;
            dataout_q  <= '0;
            dout_vld_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            dataout_q  <= dataout_d;
            dout_vld_q <= dout_vld_d;
        end
    end

    assign s        = sel;
    assign dataout  = dataout_q;
    assign dout_vld = dout_vld_q;
    assign owner    = owner_q;

endmodule

// File: tb/tb_rr_arb3x16.sv
// Bench for rr_arb3x16: a reference arbiter model with a word scoreboard, plus directed scenarios.
module tb_rr_arb3x16;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] a = '0, b = '0, c = '0;
    logic [2:0]  vld = 3'b111;
    logic [2:0]  lock = 3'b000;
    logic        dout_rdy = 1'b0;
    logic [2:0]  rdy;
    logic [1:0]  s;
    logic [15:0] dataout;
    logic        dout_vld;
    logic [1:0]  owner;

    rr_arb3x16 #(.W(16)) dut (
        .clk      (clk),
        .reset    (reset),
        .a        (a),
        .b        (b),
        .c        (c),
        .vld      (vld),
        .lock     (lock),
        .rdy      (rdy),
        .s        (s),
        .dataout  (dataout),
        .dout_vld (dout_vld),
        .dout_rdy (dout_rdy),
        .owner    (owner)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    logic [15:0] sb[$];
    logic [15:0] m_last = '0;
    logic        m_dv = 1'b0;
    logic [1:0]  m_owner = 2'd2;
    logic        m_locked = 1'b0;
    logic [2:0]  smp_rdy;
    logic [1:0]  smp_s;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s act=%0h exp=%0h t=%0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] word_of(input int i);
        if (i == 0) return a;
        if (i == 1) return b;
        return c;
    endfunction

    // The bench samples at the negedge and advances the model with the inputs that the posedge will see.
    task automatic cyc();
        logic [2:0]  e_rdy;
        logic [1:0]  e_s;
        logic [15:0] e_dat;
        int          p;
        bit          found;
        @(negedge clk);
        smp_rdy = rdy;
        smp_s   = s;
        found   = 1'b0;
        p       = int'(m_owner);
        if (m_locked) begin
            found = vld[m_owner];
        end else begin
            for (int k = 1; k <= 3; k++) begin
                int j;
                j = (int'(m_owner) + k) % 3;
                if (!found && vld[j]) begin
                    found = 1'b1;
                    p     = j;
                end
            end
        end
        e_rdy = (!reset && found && (!m_dv || dout_rdy)) ? (3'b001 << p) : 3'b000;
        e_s   = reset ? 2'd0 : (found ? 2'(p) : m_owner);
        e_dat = (m_dv && sb.size() > 0) ? sb[0] : m_last;
        chk("rdy", rdy, e_rdy);
        chk("s", s, e_s);
        chk("owner", owner, m_owner);
        chk("dout_vld", dout_vld, m_dv);
        chk("dataout", dataout, e_dat);
        if (reset) begin
            sb.delete();
            m_last   = '0;
            m_dv     = 1'b0;
            m_owner  = 2'd2;
            m_locked = 1'b0;
        end else begin
            if (m_dv && dout_rdy) begin
                if (sb.size() > 0) m_last = sb.pop_front();
                m_dv = 1'b0;
            end
            if (e_rdy != 3'b000) begin
                sb.push_back(word_of(p));
                m_last   = word_of(p);
                m_dv     = 1'b1;
                m_owner  = 2'(p);
                m_locked = lock[p];
            end
        end
        @(posedge clk);
        #1;
    endtask

    logic [15:0] rr_exp[4];

    initial begin
        rr_exp[0] = 16'h000A; rr_exp[1] = 16'h000B; rr_exp[2] = 16'h000C; rr_exp[3] = 16'h000A;

        // reset held with all requesters valid
        a = 16'h000A; b = 16'h000B; c = 16'h000C;
        cyc();
        chk("rst_rdy", smp_rdy, 3'b000);
        cyc();
        chk("rst_dout_vld", dout_vld, 1'b0);
        chk("rst_dataout", dataout, 16'h0000);
        chk("rst_owner", owner, 2'd2);

        reset = 1'b0; dout_rdy = 1'b1;
        cyc();
        chk("rel_rdy", smp_rdy, 3'b001);
        chk("rel_s", smp_s, 2'd0);

        // single requester B
        vld = 3'b010; b = 16'h1234;
        cyc();
        chk("single_rdy", smp_rdy, 3'b010);
        chk("single_s", smp_s, 2'd1);
        chk("single_dat", dataout, 16'h1234);
        chk("single_vld", dout_vld, 1'b1);
        chk("single_owner", owner, 2'd1);
        b = 16'h1235;
        cyc();
        chk("single_hold", dataout, 16'h1235);

        // round robin starting from owner=C
        b = 16'h000B; vld = 3'b100;
        cyc();
        vld = 3'b111;
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk($sformatf("rr_%0d", i), dataout, rr_exp[i]);
        end

        // backpressure on a held B word
        cyc();
        chk("bp_load", dataout, 16'h000B);
        dout_rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("bp_rdy", smp_rdy, 3'b000);
            chk("bp_dat", dataout, 16'h000B);
        end
        dout_rdy = 1'b1;
        cyc();
        chk("bp_release_rdy", smp_rdy, 3'b100);
        chk("bp_release_s", smp_s, 2'd2);

        // locked burst from C
        vld = 3'b100; lock = 3'b100; c = 16'hC001;
        cyc();
        vld = 3'b111; c = 16'hC002;
        cyc();
        chk("burst_rdy2", smp_rdy, 3'b100);
        c = 16'hC003;
        cyc();
        chk("burst_rdy3", smp_rdy, 3'b100);
        vld = 3'b011;
        cyc();
        chk("burst_gap_rdy", smp_rdy, 3'b000);
        vld = 3'b111; lock = 3'b000; c = 16'hC004;
        cyc();
        chk("burst_last_rdy", smp_rdy, 3'b100);
        chk("burst_last_dat", dataout, 16'hC004);
        cyc();
        chk("burst_after_rdy", smp_rdy, 3'b001);

        // reset in the middle of a locked burst
        vld = 3'b100; lock = 3'b100;
        cyc();
        chk("mid_pre_vld", dout_vld, 1'b1);
        reset = 1'b1;
        cyc();
        chk("mid_rst_vld", dout_vld, 1'b0);
        chk("mid_rst_owner", owner, 2'd2);
        reset = 1'b0; vld = 3'b111; lock = 3'b000;
        cyc();
        chk("mid_rel_rdy", smp_rdy, 3'b001);

        // random traffic against the model
        for (int i = 0; i < 400; i++) begin
            vld      = 3'($urandom_range(0, 7));
            lock     = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'b000;
            dout_rdy = ($urandom_range(0, 3) != 0);
            reset    = ($urandom_range(0, 63) == 0);
            a        = 16'($urandom);
            b        = 16'($urandom);
            c        = 16'($urandom);
            cyc();
        end
        reset = 1'b0; vld = 3'b000; lock = 3'b000; dout_rdy = 1'b1;
        cyc();
        cyc();

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
